adc_stim_gen: RTL and testbench
===============================

ADC_STIM_GEN -- requirements
Module: adc_stim_gen

Interface
REQ-001 Parameter: DATA_W, 12, bits per serial sample.
REQ-002 Parameter: NUM_CH, 4, channels per lane, selectable by ADDR; power of two, 2..8.
REQ-003 Parameter: PHASE_W, 16, phase accumulator width; SHALL be >= DATA_W+1.
REQ-004 Port: clk  in  1  sole clock; SCK/CS are synchronous to it.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: SCK  in  1  serial clock from the reader; data advances on falling edge.
REQ-007 Port: CS  in  1  active-low conversion/frame select.
REQ-008 Port: ADDR  in  $clog2(NUM_CH)  channel select, sampled at CS falling edge.
REQ-009 Port: MODE  in  2  waveform: 0 square, 1 sawtooth, 2 triangle, 3 sine.
REQ-010 Port: FREQ  in  PHASE_W  phase increment per conversion.
REQ-011 Port: DOUTA  out  1  lane A serial data, MSB first.
REQ-012 Port: DOUTB  out  1  lane B serial data, MSB first.
REQ-013 Port: BUSY  out  1  high while a frame is open (state SHIFT or DONE).
REQ-014 Port: CONV_CNT  out  16  number of CS falling edges, wraps 0xFFFF->0.

Function
REQ-015 Edges SHALL be detected by comparing SCK/CS with one-cycle-delayed copies; no synchronisers.
REQ-016 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on CS fall; SHIFT->DONE after DATA_W SCK falls; SHIFT/DONE->IDLE on CS rise.
REQ-017 On CS fall: latch lane samples for ADDR from current phase, then phase += FREQ (mod 2^PHASE_W), CONV_CNT += 1.
REQ-018 Channel ch phase SHALL be accumulator + ch*2^PHASE_W/NUM_CH.
REQ-019 Sample from phase p: square = p MSB ? all-ones : 0; sawtooth = p[PHASE_W-1 -: DATA_W]; triangle = t or ~t when p MSB set, t = p[PHASE_W-2 -: DATA_W].
REQ-020 Lane B sample SHALL be the bitwise complement of lane A sample.
REQ-021 DOUTA/DOUTB SHALL present the sample MSB one clk after CS fall, then the next bit one clk after each SCK fall in SHIFT.
REQ-022 In IDLE and DONE, DOUTA and DOUTB SHALL be 0; extra SCK falls in DONE are ignored.
REQ-023 CS rise mid-SHIFT SHALL abort to IDLE next cycle; phase advance and CONV_CNT are not rolled back.
REQ-024 SCK fall and CS rise in the same cycle: CS rise wins, no shift.
REQ-025 MODE, FREQ changes take effect at the next CS fall only.

Reset
REQ-026 On rst_n low: state IDLE, phase 0, CONV_CNT 0, DOUTA 0, DOUTB 0, BUSY 0, edge registers SCK=1, CS=1.
REQ-027 Reset mid-frame SHALL abandon the frame with no spurious edge after release.

Configuration
REQ-028 Macro ADC_STIM_SINE_LUT_EN defined: MODE 3 outputs quarter-wave 256-entry sine, offset binary, mid-scale 2^(DATA_W-1).
REQ-029 Macro undefined: MODE 3 outputs constant 2^(DATA_W-1); no LUT synthesised.

Structure
REQ-030 Package adc_stim_pkg SHALL hold the mode enumeration, FSM state typedef and the sine quarter-wave table function.
REQ-031 One sub-module adc_stim_shifter (DATA_W-bit parallel-load shift register with bit counter) SHALL be instantiated once per lane.

Verification
REQ-032 Defaults, MODE=1, FREQ=0x0100, ADDR=0, 3 frames -> lane A samples 0x000, 0x010, 0x020; lane B 0xFFF, 0xFEF, 0xFDF.
REQ-033 MODE=1, FREQ=0, ADDR=1 -> lane A 0x400; ADDR=3 -> 0xC00.
REQ-034 MODE=0, FREQ=0x8000 -> lane A alternates 0xFFF, 0x000 across frames; CONV_CNT increments by 1 per frame.
REQ-035 CS raised after 5 SCK falls -> BUSY 0 next cycle, DOUT 0; next frame samples the advanced phase.
REQ-036 Macro defined, MODE=3, FREQ=0x4000 -> samples 0x800, 0xFFF, 0x800, 0x000 (±1 LSB); undefined -> all 0x800.
REQ-037 rst_n pulsed low during SHIFT -> all outputs 0, CONV_CNT 0; first post-reset frame yields phase-0 sample.

Source files
------------

// File: rtl/adc_stim_pkg.sv
// Shared types for the ADC stimulus generator: waveform modes, frame FSM states
// and the quarter-wave sine table generator.
package adc_stim_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SINE   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Quarter-wave sine, Q15 amplitude for idx/256 of a quarter turn.
  // Odd Taylor series through x^9 in Horner form, Q16 coefficients; only ever
  // evaluated with constant arguments to fill a ROM.
  function automatic logic [15:0] sine_quarter(input logic [7:0] idx);
    longint x;
    longint y;
    longint t;
    longint r;
    x = longint'(idx);
    y = x * x;
    t = 11;
    t = 307 - ((t * y) >>> 16);
    t = 5223 - ((t * y) >>> 16);
    t = 42334 - ((t * y) >>> 16);
    t = 102944 - ((t * y) >>> 16);
    r = (x * t) >>> 9;
    if (r > 32767) r = 32767;
    return 16'(r);
  endfunction

endpackage

// File: rtl/adc_stim_gen_if.sv
// Serial reader-facing bus of the ADC stimulus generator. The reader (master)
// drives SCK/CS/ADDR/MODE/FREQ; the generator (slave) returns two data lanes.
interface adc_stim_gen_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 16
);
  localparam int ADDR_W = $clog2(NUM_CH);

  // Handshake: a frame opens on CS falling (ADDR/MODE/FREQ sampled there) and
  // closes on CS rising. The MSB appears on DOUTA/DOUTB one clk after the CS
  // fall and each later bit one clk after an SCK fall; BUSY marks an open frame.
  logic              SCK;
  logic              CS;
  logic [ADDR_W-1:0] ADDR;
  logic [1:0]        MODE;
  logic [PHASE_W-1:0] FREQ;
  logic              DOUTA;
  logic              DOUTB;
  logic              BUSY;
  logic [15:0]       CONV_CNT;

  modport master (
    output SCK, CS, ADDR, MODE, FREQ,
    input  DOUTA, DOUTB, BUSY, CONV_CNT
  );

  modport slave (
    input  SCK, CS, ADDR, MODE, FREQ,
    output DOUTA, DOUTB, BUSY, CONV_CNT
  );

endinterface

// File: rtl/adc_stim_shifter.sv
// One serial lane: parallel-load MSB-first shift register plus a count of the
// bits shifted since the last load.
module adc_stim_shifter #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= {sreg[DATA_W-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
    end
  end

  assign bit_out = sreg[DATA_W-1];
  // High while the final bit is on the line, so the next shift ends the word.
  assign last    = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/adc_stim_gen.sv
// Multi-channel ADC emulator: phase-accumulator waveform sampled per frame and
// shifted out on two complementary lanes. Define ADC_STIM_SINE_LUT_EN for a real sine in MODE 3.
module adc_stim_gen
  import adc_stim_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  adc_stim_gen_if.slave bus,
  output state_t fsm_state
);

  localparam int ADDR_W   = $clog2(NUM_CH);
  localparam int CH_SHIFT = PHASE_W - ADDR_W;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state;
  state_t state_next;

  logic sck_q;
  logic cs_q;
  logic armed;
  logic cs_fall;
  logic cs_rise;
  logic sck_fall;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ch_phase;
  logic [15:0]        conv_cnt;

  logic               load;
  logic               shift_en;
  logic               last_a;
  logic               last_b;
  logic               bit_a;
  logic               bit_b;
  mode_t              mode_sel;
  logic [DATA_W-1:0]  tri_t;
  logic [DATA_W-1:0]  sample_a;
  logic [DATA_W-1:0]  sine_sample;
  logic               unused_bits;

  // armed stays low for the first cycle after reset so a CS or SCK already low
  // at release is absorbed into the delayed copies instead of reading as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b1;
      cs_q  <= 1'b1;
      armed <= 1'b0;
    end else begin
      sck_q <= bus.SCK;
      cs_q  <= bus.CS;
      armed <= 1'b1;
    end
  end

  assign cs_fall  = armed & cs_q & ~bus.CS;
  assign cs_rise  = armed & ~cs_q & bus.CS;
  assign sck_fall = armed & sck_q & ~bus.SCK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SHIFT;
          load       = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A CS rise takes priority over an SCK fall in the same cycle.
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (sck_fall) begin
          shift_en = 1'b1;
          if (last_a & last_b) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      conv_cnt <= '0;
    end else if (cs_fall) begin
      acc      <= acc + bus.FREQ;
      conv_cnt <= conv_cnt + 16'd1;
    end
  end

  // Channels sit at equal fractions of a turn from the shared accumulator.
  assign ch_phase    = acc + (PHASE_W'(bus.ADDR) << CH_SHIFT);
  assign mode_sel    = mode_t'(bus.MODE);
  assign tri_t       = ch_phase[PHASE_W-2 -: DATA_W];
  assign unused_bits = ^ch_phase;

`ifdef ADC_STIM_SINE_LUT_EN
  logic [15:0]       sine_rom [256];
  logic [7:0]        sine_idx;
  logic [15:0]       sine_q15;
  logic [DATA_W-1:0] sine_amp;

  for (genvar i = 0; i < 256; i++) begin : g_sine_rom
    assign sine_rom[i] = sine_quarter(8'(i));
  end

  // Odd quadrants walk the quarter table backwards; the upper half goes below mid-scale.
  assign sine_idx    = ch_phase[PHASE_W-2] ? ~ch_phase[PHASE_W-3 -: 8] : ch_phase[PHASE_W-3 -: 8];
  assign sine_q15    = sine_rom[sine_idx];
  assign sine_amp    = DATA_W'((32'(sine_q15) << (DATA_W - 1)) >> 15);
  assign sine_sample = ch_phase[PHASE_W-1] ? (MID - sine_amp) : (MID + sine_amp);
`else
  assign sine_sample = MID;
`endif

  always_comb begin
    sample_a = '0;
    unique case (mode_sel)
      MODE_SQUARE: sample_a = ch_phase[PHASE_W-1] ? '1 : '0;
      MODE_SAW:    sample_a = ch_phase[PHASE_W-1 -: DATA_W];
      MODE_TRI:    sample_a = ch_phase[PHASE_W-1] ? ~tri_t : tri_t;
      MODE_SINE:   sample_a = sine_sample;
      default:     sample_a = '0;
    endcase
  end

  adc_stim_shifter #(.DATA_W(DATA_W)) u_lane_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (sample_a),
    .shift     (shift_en),
    .bit_out   (bit_a),
    .last      (last_a)
  );

  adc_stim_shifter #(.DATA_W(DATA_W)) u_lane_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (~sample_a),
    .shift     (shift_en),
    .bit_out   (bit_b),
    .last      (last_b)
  );

  assign bus.DOUTA    = (state == ST_SHIFT) & bit_a;
  assign bus.DOUTB    = (state == ST_SHIFT) & bit_b;
  assign bus.BUSY     = (state != ST_IDLE);
  assign bus.CONV_CNT = conv_cnt;
  assign fsm_state    = state;

endmodule

// File: tb/tb_adc_stim_gen.sv
// Directed bench for adc_stim_gen: expected lane words are queued when a frame
// is requested and compared once the frame has been shifted out.
`timescale 1ns/1ps
module tb_adc_stim_gen;
  import adc_stim_pkg::*;

  localparam int DW  = 12;
  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int AW  = $clog2(NCH);

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t fsm_state;

  int errors = 0;
  int checks = 0;
  int tol = 0;
  logic [2*DW-1:0] exp_q[$];

  adc_stim_gen_if #(.NUM_CH(NCH), .PHASE_W(PW)) bus();

  adc_stim_gen #(.DATA_W(DW), .NUM_CH(NCH), .PHASE_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    int diff;
    diff = int'(obs) - int'(exp);
    if (diff < 0) diff = -diff;
    checks++;
    assert (diff <= tol) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_q.push_back({a, b});
  endtask

  task automatic do_reset();
    bus.SCK = 1'b1;
    bus.CS  = 1'b1;
    rst_n   = 1'b0;
    tick(2);
    check("rst_douta", 32'(bus.DOUTA), 32'd0);
    check("rst_doutb", 32'(bus.DOUTB), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_conv_cnt", 32'(bus.CONV_CNT), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic open_frame(input logic [AW-1:0] addr);
    bus.ADDR = addr;
    bus.CS   = 1'b0;
    tick();
  endtask

  task automatic shift_bits(input int n, output logic [DW-1:0] a, output logic [DW-1:0] b);
    a = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      a = {a[DW-2:0], bus.DOUTA};
      b = {b[DW-2:0], bus.DOUTB};
      bus.SCK = 1'b0;
      tick();
      bus.SCK = 1'b1;
      tick();
    end
  endtask

  task automatic full_frame(input logic [AW-1:0] addr, input string tag, input int extra_sck = 0);
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] e;
    open_frame(addr);
    check({tag, "_busy_open"}, 32'(bus.BUSY), 32'd1);
    shift_bits(DW, a, b);
    // SCK falls after the last bit must leave the frame parked in DONE.
    for (int i = 0; i < extra_sck; i++) begin
      bus.SCK = 1'b0;
      tick();
      bus.SCK = 1'b1;
      tick();
    end
    check({tag, "_done_state"}, 32'(fsm_state), 32'(ST_DONE));
    check({tag, "_done_dout"}, 32'({bus.DOUTA, bus.DOUTB}), 32'd0);
    bus.CS = 1'b1;
    tick();
    check({tag, "_busy_close"}, 32'(bus.BUSY), 32'd0);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_queue: observed=empty expected=pending entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_word({tag, "_lane_a"}, a, e[2*DW-1:DW]);
      check_word({tag, "_lane_b"}, b, e[DW-1:0]);
    end
  endtask

  initial begin
    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    logic [15:0]   cnt0;

    bus.ADDR = '0;
    bus.MODE = 2'd1;
    bus.FREQ = '0;

    // Sawtooth ramp on channel 0, complementary lane B.
    do_reset();
    bus.MODE = 2'd1;
    bus.FREQ = 16'h0100;
    push_exp(12'h000, 12'hFFF);
    push_exp(12'h010, 12'hFEF);
    push_exp(12'h020, 12'hFDF);
    full_frame(2'd0, "saw0", 2);
    full_frame(2'd0, "saw1");
    full_frame(2'd0, "saw2");
    check("saw_conv_cnt", 32'(bus.CONV_CNT), 32'd3);

    // Channel offsets at a frozen phase of zero.
    do_reset();
    bus.MODE = 2'd1;
    bus.FREQ = 16'h0000;
    push_exp(12'h400, 12'hBFF);
    push_exp(12'hC00, 12'h3FF);
    push_exp(12'h800, 12'h7FF);
    full_frame(2'd1, "ch1");
    full_frame(2'd3, "ch3");
    full_frame(2'd2, "ch2");

    // Square wave toggling at half a turn per frame.
    bus.MODE = 2'd0;
    bus.FREQ = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      pa = (i % 2 == 0) ? 12'h000 : 12'hFFF;
      push_exp(pa, ~pa);
      cnt0 = bus.CONV_CNT;
      full_frame(2'd0, "square");
      check("square_conv_step", 32'(bus.CONV_CNT), 32'(cnt0 + 16'd1));
    end

    // Triangle at quarter-turn steps.
    do_reset();
    bus.MODE = 2'd2;
    bus.FREQ = 16'h4000;
    push_exp(12'h000, 12'hFFF);
    push_exp(12'h800, 12'h7FF);
    push_exp(12'hFFF, 12'h000);
    push_exp(12'h7FF, 12'h800);
    for (int i = 0; i < 4; i++) full_frame(2'd0, "tri");

    // Abort after 5 bits with a same-cycle SCK fall; phase stays advanced.
    do_reset();
    bus.MODE = 2'd1;
    bus.FREQ = 16'h0100;
    open_frame(2'd0);
    shift_bits(5, pa, pb);
    check("abort_bits_a", 32'(pa[4:0]), 32'h00);
    check("abort_bits_b", 32'(pb[4:0]), 32'h1F);
    bus.CS  = 1'b1;
    bus.SCK = 1'b0;
    tick();
    bus.SCK = 1'b1;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_dout", 32'({bus.DOUTA, bus.DOUTB}), 32'd0);
    tick();
    push_exp(12'h010, 12'hFEF);
    full_frame(2'd0, "after_abort");
    check("abort_conv_cnt", 32'(bus.CONV_CNT), 32'd2);

    // Sine at quarter-turn steps.
    do_reset();
    bus.MODE = 2'd3;
    bus.FREQ = 16'h4000;
`ifdef ADC_STIM_SINE_LUT_EN
    tol = 1;
    push_exp(12'h800, 12'h7FF);
    push_exp(12'hFFF, 12'h000);
    push_exp(12'h800, 12'h7FF);
    push_exp(12'h000, 12'hFFF);
`else
    tol = 0;
    for (int i = 0; i < 4; i++) push_exp(12'h800, 12'h7FF);
`endif
    for (int i = 0; i < 4; i++) full_frame(2'd0, "sine");
    tol = 0;

    // Reset asserted mid-SHIFT with CS held low through release.
    do_reset();
    bus.MODE = 2'd1;
    bus.FREQ = 16'h0100;
    push_exp(12'h000, 12'hFFF);
    full_frame(2'd0, "pre_reset");
    open_frame(2'd0);
    shift_bits(3, pa, pb);
    check("mid_reset_dout_b_before", 32'(bus.DOUTB), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_reset_dout", 32'({bus.DOUTA, bus.DOUTB}), 32'd0);
    check("mid_reset_busy", 32'(bus.BUSY), 32'd0);
    check("mid_reset_conv_cnt", 32'(bus.CONV_CNT), 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("post_reset_no_edge_busy", 32'(bus.BUSY), 32'd0);
    check("post_reset_no_edge_cnt", 32'(bus.CONV_CNT), 32'd0);
    bus.CS = 1'b1;
    tick();
    push_exp(12'h000, 12'hFFF);
    full_frame(2'd0, "post_reset");
    check("post_reset_conv_cnt", 32'(bus.CONV_CNT), 32'd1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover_queue: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
